// File: rtl/keypad_scan4x4_if.sv
// rtl/keypad_scan4x4_if.sv - keypad matrix lines and CPU read-side signals of the scanner
//
// Purpose: bundles the keypad wiring (i_row/o_col) and the CPU view
// (cs strobe, key code, flags, digit shift register) of keypad_scan4x4.
// Ports (slave = scanner side):
//   cs        in   read strobe, acknowledges the pending key event
//   i_row     in   keypad rows, active-low, asynchronous
//   o_col     out  column drive, active-low, one-hot-zero
//   o_key     out  last accepted key code
//   o_valid   out  unread key event pending
//   o_ovf     out  event accepted while o_valid was still set
//   o_digits  out  last 8 accepted codes, newest in [3:0]
interface keypad_scan4x4_if;
    logic        cs;
    logic [3:0]  i_row;
    logic [3:0]  o_col;
    logic [3:0]  o_key;
    logic        o_valid;
    logic        o_ovf;
    logic [31:0] o_digits;

    modport master (
        output cs, i_row,
        input  o_col, o_key, o_valid, o_ovf, o_digits
    );

    modport slave (
        input  cs, i_row,
        output o_col, o_key, o_valid, o_ovf, o_digits
    );
endinterface

// File: rtl/keypad_scan4x4.sv
// rtl/keypad_scan4x4.sv - 4x4 matrix keypad scanner, debouncer and key-code register
//
// Purpose: drives one keypad column at a time for SCAN_DIV cycles, samples
// the synchronized rows at the end of each dwell, builds a 16-bit frame map
// and resolves a single pressed key per frame. A debounce FSM accepts a
// press (or release) after DEBOUNCE identical frames.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   bus    slave modport of keypad_scan4x4_if (rows/columns and CPU read side)
module keypad_scan4x4 #(
    parameter int SCAN_DIV = 4096,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scan4x4_if.slave  bus
);
    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW   = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [DIVW-1:0] r_div;
    logic [1:0]      r_col;
    logic [3:0]      r_col_drv;
    logic [3:0]      r_row_s1;
    logic [3:0]      r_row_s2;
    logic [15:0]     r_map;
    state_t          r_state;
    logic [DW-1:0]   r_dcnt;
    logic [3:0]      r_cand;
    logic [3:0]      r_key;
    logic            r_valid;
    logic            r_ovf;
    logic [31:0]     r_digits;

    logic            w_tick;
    logic            w_frame_done;
    logic [15:0]     w_frame;
    logic [4:0]      w_nbits;
    logic [3:0]      w_idx;
    logic            w_key_found;
    logic [3:0]      w_code;
    logic [DW-1:0]   w_dcnt_inc;
    logic            w_reach;
    logic            w_accept;
    logic [3:0]      w_acc_code;

    assign bus.o_col    = r_col_drv;
    assign bus.o_key    = r_key;
    assign bus.o_valid  = r_valid;
    assign bus.o_ovf    = r_ovf;
    assign bus.o_digits = r_digits;

    assign w_tick       = (r_div == DIVW'(SCAN_DIV - 1));
    assign w_frame_done = w_tick && (r_col == 2'd3);

    // The frame result must include column 3, which is only being written
    // into r_map on this same edge, so splice the live sample in here.
    always_comb begin
        w_frame        = r_map;
        w_frame[15:12] = ~r_row_s2;
    end

    // Map bit index is col*4+row; remember the last set bit and the count.
    always_comb begin
        w_nbits = 5'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame[i]) begin
                w_nbits = w_nbits + 5'd1;
                w_idx   = 4'(i);
            end
        end
    end

    assign w_key_found = (w_nbits == 5'd1);
    // Key code is row*4+col, i.e. the two index fields swapped.
    assign w_code      = {w_idx[1:0], w_idx[3:2]};

    assign w_dcnt_inc  = (r_dcnt == DW'(DEBOUNCE)) ? r_dcnt : r_dcnt + DW'(1);
    assign w_reach     = (w_dcnt_inc == DW'(DEBOUNCE));

    assign w_accept    = w_frame_done && w_key_found &&
                         (((r_state == S_IDLE) && (DEBOUNCE == 1)) ||
                          ((r_state == S_PRESS) && (w_code == r_cand) && w_reach));
    assign w_acc_code  = (r_state == S_IDLE) ? w_code : r_cand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_col     <= 2'd0;
            r_col_drv <= 4'b1110;
            r_row_s1  <= 4'hF;
            r_row_s2  <= 4'hF;
            r_map     <= 16'h0000;
            r_state   <= S_IDLE;
            r_dcnt    <= '0;
            r_cand    <= 4'h0;
            r_key     <= 4'h0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_digits  <= 32'h0;
        end else begin
            r_row_s1 <= bus.i_row;
            r_row_s2 <= r_row_s1;

            if (w_tick) begin
                r_div                     <= '0;
                r_map[{r_col, 2'b00} +: 4] <= ~r_row_s2;
                r_col                     <= r_col + 2'd1;
                r_col_drv                 <= ~(4'b0001 << (r_col + 2'd1));
            end else begin
                r_div <= r_div + DIVW'(1);
            end

            if (w_frame_done) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_key_found) begin
                            r_cand  <= w_code;
                            r_dcnt  <= DW'(1);
                            r_state <= (DEBOUNCE == 1) ? S_HELD : S_PRESS;
                        end
                    end
                    S_PRESS: begin
                        if (!w_key_found) begin
                            r_state <= S_IDLE;
                        end else if (w_code != r_cand) begin
                            r_cand <= w_code;
                            r_dcnt <= DW'(1);
                        end else begin
                            r_dcnt <= w_dcnt_inc;
                            if (w_reach) begin
                                r_state <= S_HELD;
                            end
                        end
                    end
                    S_HELD: begin
                        // No auto-repeat: any key, even a different one, keeps us here.
                        if (!w_key_found) begin
                            r_dcnt  <= DW'(1);
                            r_state <= (DEBOUNCE == 1) ? S_IDLE : S_RELEASE;
                        end
                    end
                    default: begin
                        if (w_key_found) begin
                            r_state <= S_HELD;
                        end else begin
                            r_dcnt <= w_dcnt_inc;
                            if (w_reach) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                endcase
            end

            // An accept on the same edge as a read strobe takes priority.
            if (w_accept) begin
                r_key    <= w_acc_code;
                r_digits <= {r_digits[27:0], w_acc_code};
                r_ovf    <= r_ovf | r_valid;
                r_valid  <= 1'b1;
            end else if (bus.cs) begin
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb/tb_keypad_scan4x4.sv - self-checking bench for keypad_scan4x4 with a keypad and key-event model
module tb_keypad_scan4x4;
    localparam int FRAME = 16;
    localparam int DEB   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] held;
    logic        cs_drv;
    logic [3:0]  w_row;

    int checks   = 0;
    int failures = 0;

    // Reference state: outputs plus run-length view of frame results.
    logic [3:0]  m_key;
    logic        m_valid;
    logic        m_ovf;
    logic [31:0] m_digits;
    int          m_run_val;
    int          m_run_len;
    bit          m_down;

    always #5 clk = ~clk;

    keypad_scan4x4_if kif();

    keypad_scan4x4 #(.SCAN_DIV(4), .DEBOUNCE(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif)
    );

    // Keypad: row r is pulled low when a held key in that row sits on a driven column.
    always_comb begin
        w_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !kif.o_col[c]) w_row[r] = 1'b0;
    end
    assign kif.i_row = w_row;
    assign kif.cs    = cs_drv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key = 4'h0; m_valid = 1'b0; m_ovf = 1'b0; m_digits = 32'h0;
        m_run_val = -1; m_run_len = 0; m_down = 1'b0;
    endtask

    // One full frame with a fixed key set; cs_cyc selects the edge (1..16) with cs high, 0 = none.
    task automatic frame(input logic [15:0] keys, input int cs_cyc, input bit chk_col);
        int  res;
        bit  acc;
        logic [3:0] ecol;
        held = keys;
        for (int n = 1; n <= FRAME; n++) begin
            cs_drv = (n == cs_cyc);
            @(posedge clk);
            #1;
            cs_drv = 1'b0;
            if (chk_col) begin
                ecol = ~(4'b0001 << ((n / 4) % 4));
                chk("col_seq", {28'h0, kif.o_col}, {28'h0, ecol});
            end
            if (n == cs_cyc && n != FRAME) begin
                m_valid = 1'b0; m_ovf = 1'b0;
                chk("cs_valid", {31'h0, kif.o_valid}, 32'h0);
                chk("cs_ovf", {31'h0, kif.o_ovf}, 32'h0);
            end
        end
        res = -1;
        if ($countones(keys) == 1)
            for (int i = 0; i < 16; i++) if (keys[i]) res = i;
        if (res == m_run_val) m_run_len++;
        else begin m_run_val = res; m_run_len = 1; end
        acc = 1'b0;
        if (!m_down && res >= 0 && m_run_len >= DEB) begin
            acc = 1'b1; m_down = 1'b1;
        end else if (m_down && res < 0 && m_run_len >= DEB) begin
            m_down = 1'b0;
        end
        if (acc) begin
            m_key = 4'(res);
            m_digits = {m_digits[27:0], 4'(res)};
            m_ovf = m_ovf | m_valid;
            m_valid = 1'b1;
        end else if (cs_cyc == FRAME) begin
            m_valid = 1'b0; m_ovf = 1'b0;
        end
        chk("key", {28'h0, kif.o_key}, {28'h0, m_key});
        chk("valid", {31'h0, kif.o_valid}, {31'h0, m_valid});
        chk("ovf", {31'h0, kif.o_ovf}, {31'h0, m_ovf});
        chk("digits", kif.o_digits, m_digits);
    endtask

    function automatic logic [15:0] kbit(input int code);
        logic [15:0] v;
        v = 16'h0;
        v[code] = 1'b1;
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"}, {28'h0, kif.o_col}, 32'hE);
        chk({tag, "_key"}, {28'h0, kif.o_key}, 32'h0);
        chk({tag, "_valid"}, {31'h0, kif.o_valid}, 32'h0);
        chk({tag, "_ovf"}, {31'h0, kif.o_ovf}, 32'h0);
        chk({tag, "_digits"}, kif.o_digits, 32'h0);
    endtask

    initial begin
        logic [15:0] rk;
        int          sel;
        int          hold_n;

        reset = 1'b1; cs_drv = 1'b0; held = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk) reset = 1'b0;

        // Build up some state, then reset mid-scan.
        repeat (3) frame(kbit(10), 0, 1'b0);
        frame(16'h0, 0, 1'b0);
        held = 16'h0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(negedge clk) reset = 1'b0;
        frame(16'h0, 0, 1'b1);
        frame(16'h0, 0, 1'b1);

        // Key (1,2) held for 5 frames: exactly one event.
        repeat (5) frame(kbit(6), 0, 1'b0);
        chk("k6_key", {28'h0, kif.o_key}, 32'h6);
        chk("k6_valid", {31'h0, kif.o_valid}, 32'h1);
        chk("k6_digits", kif.o_digits, 32'h00000006);
        frame(16'h0, 5, 1'b0);
        frame(16'h0, 0, 1'b0);

        // Key (0,3) for a single frame is rejected.
        frame(kbit(3), 0, 1'b0);
        repeat (3) frame(16'h0, 0, 1'b0);
        chk("bounce_valid", {31'h0, kif.o_valid}, 32'h0);
        chk("bounce_digits", kif.o_digits, 32'h00000006);

        // Ghosting: (0,0)+(2,1) rejected, then (0,0) alone accepted.
        repeat (5) frame(kbit(0) | kbit(9), 0, 1'b0);
        chk("ghost_valid", {31'h0, kif.o_valid}, 32'h0);
        repeat (3) frame(kbit(0), 0, 1'b0);
        chk("ghost_rel_key", {28'h0, kif.o_key}, 32'h0);
        chk("ghost_rel_valid", {31'h0, kif.o_valid}, 32'h1);
        frame(16'h0, 8, 1'b0);
        frame(16'h0, 0, 1'b0);

        // Overrun, cs clear, then cs on the accept edge.
        repeat (3) frame(kbit(3), 0, 1'b0);
        repeat (2) frame(16'h0, 0, 1'b0);
        repeat (3) frame(kbit(5), 0, 1'b0);
        chk("ovf_key", {28'h0, kif.o_key}, 32'h5);
        chk("ovf_valid", {31'h0, kif.o_valid}, 32'h1);
        chk("ovf_ovf", {31'h0, kif.o_ovf}, 32'h1);
        frame(kbit(5), 3, 1'b0);
        repeat (2) frame(16'h0, 0, 1'b0);
        frame(kbit(7), 0, 1'b0);
        frame(kbit(7), FRAME, 1'b0);
        chk("cs_acc_valid", {31'h0, kif.o_valid}, 32'h1);
        chk("cs_acc_ovf", {31'h0, kif.o_ovf}, 32'h0);
        chk("cs_acc_key", {28'h0, kif.o_key}, 32'h7);
        repeat (2) frame(16'h0, 0, 1'b0);

        // Keys 1..9, each released fully.
        for (int k = 1; k <= 9; k++) begin
            repeat (2) frame(kbit(k), 0, 1'b0);
            repeat (2) frame(16'h0, 0, 1'b0);
        end
        chk("digits_seq", kif.o_digits, 32'h23456789);

        // Randomized key patterns held for random frame counts with random reads.
        for (int g = 0; g < 40; g++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       rk = 16'h0;
                1, 2, 3: rk = kbit($urandom_range(0, 15));
                default: rk = kbit($urandom_range(0, 15)) | kbit($urandom_range(0, 15));
            endcase
            hold_n = $urandom_range(1, 4);
            for (int f = 0; f < hold_n; f++)
                frame(rk, ($urandom_range(0, 3) == 0) ? $urandom_range(1, FRAME) : 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
